// File: rtl/axis_pattern_source.sv
// axis_pattern_source: AXI-stream burst source emitting SEED + k*STRIDE words,
// with optional idle gaps between accepted words and a done pulse per burst.
module axis_pattern_source #(
    parameter int DATA_WIDTH = 10,
    parameter int WORD_COUNT = 16,
    parameter int SEED       = 0,
    parameter int STRIDE     = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    input  logic                  ready,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;
    localparam logic [15:0]           LAST_IDX = 16'(WORD_COUNT - 1);
    localparam logic [7:0]            GAP_LOAD = 8'(GAP_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] SEED_W   = DATA_WIDTH'(SEED);
    localparam logic [DATA_WIDTH-1:0] STRIDE_W = DATA_WIDTH'(STRIDE);
    state_t                state_q, state_d;
    logic [15:0]           idx_q, idx_d;
    logic [7:0]            gap_q, gap_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_d, last_d, done_d, busy_d;
    // Index and data advance at the accepting edge, so a gap only has to count down.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        data_d  = data;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = SEND;
                idx_d   = '0;
                data_d  = SEED_W;
                valid_d = 1'b1;
            end
            SEND: begin
                valid_d = 1'b1;
                if (ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = FINISH;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 16'd1;
                        data_d = data + STRIDE_W;
                        if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
            end
            GAP: if (gap_q == 8'd0) begin
                state_d = SEND;
                valid_d = 1'b1;
            end else begin
                gap_d = gap_q - 8'd1;
            end
            FINISH: state_d = IDLE;
        endcase
        last_d = valid_d && (idx_d == LAST_IDX);
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            data    <= '0;
            valid   <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            data    <= data_d;
            valid   <= valid_d;
            last    <= last_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end
endmodule

// File: tb/tb_axis_pattern_source.sv
// tb_axis_pattern_source: four parameterisations of the burst source checked
// through a shared scoreboard plus table-driven and hand-written sequences.
module tb_axis_pattern_source;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start = '0, ready = '0;
    logic [3:0] valid, last, busy, done;
    logic [9:0] data0, data1, data3;
    logic [3:0] data2;
    logic [1:0] sel = 2'd0;
    logic       m_valid, m_last, m_ready;
    logic [9:0] m_data;
    int tests = 0, fails = 0;

    typedef struct { logic [9:0] d; logic l; } sb_t;
    sb_t sbq[$];

    typedef struct { int sel; bit st; bit rdy; bit v; int d; bit l; bit dn; bit bz; } row_t;
    row_t rows[17];

    always #5 clk = ~clk;

    axis_pattern_source u0 (.clk(clk), .rst(rst), .start(start[0]), .valid(valid[0]), .data(data0),
        .last(last[0]), .ready(ready[0]), .busy(busy[0]), .done(done[0]));
    axis_pattern_source #(.GAP_CYCLES(2)) u1 (.clk(clk), .rst(rst), .start(start[1]), .valid(valid[1]),
        .data(data1), .last(last[1]), .ready(ready[1]), .busy(busy[1]), .done(done[1]));
    axis_pattern_source #(.DATA_WIDTH(4), .SEED(14), .STRIDE(3), .WORD_COUNT(4)) u2 (.clk(clk), .rst(rst),
        .start(start[2]), .valid(valid[2]), .data(data2), .last(last[2]), .ready(ready[2]), .busy(busy[2]),
        .done(done[2]));
    axis_pattern_source #(.WORD_COUNT(1), .SEED(5)) u3 (.clk(clk), .rst(rst), .start(start[3]),
        .valid(valid[3]), .data(data3), .last(last[3]), .ready(ready[3]), .busy(busy[3]), .done(done[3]));

    always_comb begin
        m_valid = valid[sel];
        m_last  = last[sel];
        m_ready = ready[sel];
        m_data  = sel == 2'd0 ? data0 : sel == 2'd1 ? data1 : sel == 2'd2 ? {6'd0, data2} : data3;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d, input logic l);
        sb_t e;
        e.d = d;
        e.l = l;
        sbq.push_back(e);
    endtask

    task automatic push_ramp(input int n, input int total);
        for (int k = 0; k < n; k++) push(10'(k), k == total - 1);
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sbq.size() == 0) check("sb_underflow", sbq.size(), 1);
            else begin
                sb_t e;
                e = sbq.pop_front();
                check("sb_data", m_data, e.d);
                check("sb_last", m_last, e.l);
            end
        end
    end

    initial begin
        int busy_cnt, cyc;
        bit seen_done, prev_stall;
        logic [9:0] pd;
        logic pl;
        bit pat[4] = '{1, 0, 0, 1};
        rows[0]  = '{2, 1, 1, 0, 0, 0, 0, 0};
        rows[1]  = '{2, 0, 1, 1, 14, 0, 0, 1};
        rows[2]  = '{2, 0, 0, 1, 1, 0, 0, 1};
        rows[3]  = '{2, 0, 1, 1, 1, 0, 0, 1};
        rows[4]  = '{2, 0, 1, 1, 4, 0, 0, 1};
        rows[5]  = '{2, 0, 0, 1, 7, 1, 0, 1};
        rows[6]  = '{2, 0, 0, 1, 7, 1, 0, 1};
        rows[7]  = '{2, 0, 1, 1, 7, 1, 0, 1};
        rows[8]  = '{2, 0, 1, 0, 0, 0, 1, 1};
        rows[9]  = '{2, 0, 1, 0, 0, 0, 0, 0};
        rows[10] = '{3, 1, 0, 0, 0, 0, 0, 0};
        rows[11] = '{3, 0, 0, 1, 5, 1, 0, 1};
        rows[12] = '{3, 0, 0, 1, 5, 1, 0, 1};
        rows[13] = '{3, 0, 0, 1, 5, 1, 0, 1};
        rows[14] = '{3, 0, 1, 1, 5, 1, 0, 1};
        rows[15] = '{3, 0, 1, 0, 0, 0, 1, 1};
        rows[16] = '{3, 0, 1, 0, 0, 0, 0, 0};

        // reset state, with start asserted to confirm reset wins
        start = 4'hf;
        ready = 4'hf;
        tick();
        tick();
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data0", data0, 0);
        check("rst_data1", data1, 0);
        check("rst_data2", data2, 0);
        check("rst_data3", data3, 0);
        start = '0;
        ready = '0;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("idle_wait_busy", busy, 0);

        // defaults, ready held high
        tick();
        sel = 2'd0;
        ready[0] = 1'b1;
        push_ramp(16, 16);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("def_valid", valid[0], 1);
            check("def_data", data0, k);
            check("def_last", last[0], k == 15);
            check("def_done_low", done[0], 0);
            busy_cnt += int'(busy[0]);
            tick();
        end
        @(negedge clk);
        check("def_done", done[0], 1);
        check("def_fin_valid", valid[0], 0);
        check("def_fin_last", last[0], 0);
        busy_cnt += int'(busy[0]);
        check("def_busy_cycles", busy_cnt, 17);
        tick();

        // start in the cycle right after done, then backpressure 1,0,0,1
        start[0] = 1'b1;
        push_ramp(16, 16);
        @(negedge clk);
        check("ret_idle_busy", busy[0], 0);
        check("ret_done_once", done[0], 0);
        tick();
        start[0] = 1'b0;
        cyc = 0;
        seen_done = 0;
        prev_stall = 0;
        pd = '0;
        pl = 1'b0;
        while (!seen_done && cyc < 200) begin
            ready[0] = pat[cyc % 4];
            @(negedge clk);
            if (cyc == 0) check("ret_start_valid", valid[0], 1);
            if (prev_stall) begin
                check("bp_hold_valid", valid[0], 1);
                check("bp_hold_data", data0, pd);
                check("bp_hold_last", last[0], pl);
            end
            prev_stall = valid[0] && !ready[0];
            pd = data0;
            pl = last[0];
            seen_done = done[0];
            tick();
            cyc++;
        end
        check("bp_done_seen", seen_done, 1);
        check("bp_sb_empty", sbq.size(), 0);

        // start while busy, then reset mid-burst
        ready[0] = 1'b1;
        push_ramp(8, 16);
        start[0] = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            start[0] = k == 5;
            @(negedge clk);
            check("sb5_valid", valid[0], 1);
            check("sb5_data", data0, k);
            tick();
        end
        start[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_beat8", data0, 8);
        tick();
        rst = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("mid_valid", valid[0], 0);
            check("mid_done", done[0], 0);
            check("mid_busy", busy[0], 0);
            tick();
        end
        push_ramp(16, 16);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        @(negedge clk);
        check("restart_valid", valid[0], 1);
        check("restart_seed", data0, 0);
        seen_done = 0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            tick();
            @(negedge clk);
            seen_done = done[0];
        end
        check("restart_done", seen_done, 1);
        check("restart_sb_empty", sbq.size(), 0);
        tick();

        // gap insertion, GAP_CYCLES=2
        sel = 2'd1;
        ready[1] = 1'b1;
        push_ramp(16, 16);
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        for (int c = 0; c <= 46; c++) begin
            @(negedge clk);
            check("gap_valid", valid[1], (c % 3 == 0) && c <= 45);
            check("gap_last", last[1], c == 45);
            check("gap_done", done[1], c == 46);
            tick();
        end
        check("gap_sb_empty", sbq.size(), 0);

        // wrap-around and single-word bursts from the table
        push(10'd14, 1'b0);
        push(10'd1, 1'b0);
        push(10'd4, 1'b0);
        push(10'd7, 1'b1);
        push(10'd5, 1'b1);
        for (int i = 0; i < 17; i++) begin
            sel = 2'(rows[i].sel);
            start = '0;
            start[sel] = rows[i].st;
            ready[sel] = rows[i].rdy;
            @(negedge clk);
            check($sformatf("tbl%0d_valid", i), valid[sel], rows[i].v);
            check($sformatf("tbl%0d_last", i), last[sel], rows[i].l);
            check($sformatf("tbl%0d_done", i), done[sel], rows[i].dn);
            check($sformatf("tbl%0d_busy", i), busy[sel], rows[i].bz);
            if (rows[i].v) check($sformatf("tbl%0d_data", i), m_data, rows[i].d);
            tick();
        end
        start = '0;
        check("tbl_sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_pattern_source.md
AXIS_PATTERN_SOURCE -- requirements
Module: axis_pattern_source

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 10, giving the width of data.
REQ-002 The module SHALL have parameter WORD_COUNT, default 16, giving the words per burst (legal range 1..65535).
REQ-003 The module SHALL have parameter SEED, default 0, giving the value of word 0.
REQ-004 The module SHALL have parameter STRIDE, default 1, giving the increment between consecutive words.
REQ-005 The module SHALL have parameter GAP_CYCLES, default 0, giving the idle cycles with valid low after each accepted word (legal range 0..255).
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port start, input, 1 bit: a request to begin one burst.
REQ-009 The module SHALL have port valid, output, 1 bit: the AXI-stream valid.
REQ-010 The module SHALL have port data, output, DATA_WIDTH bits: the AXI-stream payload.
REQ-011 The module SHALL have port last, output, 1 bit: high on the final word of a burst.
REQ-012 The module SHALL have port ready, input, 1 bit: the AXI-stream ready from the sink.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: a one-cycle pulse after the final word is accepted.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SEND, GAP and FINISH.
REQ-016 In IDLE with start=1, the FSM SHALL move to SEND at the next edge, with index=0, valid=1 and data=SEED.
REQ-017 The FSM SHALL transition from IDLE to SEND with a latency of one cycle from start to valid.
REQ-018 Word k SHALL equal (SEED + k*STRIDE) mod 2^DATA_WIDTH, with the upper bits truncated.
REQ-019 Wrap-around of data SHALL NOT be flagged.
REQ-020 A transfer SHALL occur only when valid=1 and ready=1 on the same edge.
REQ-021 While valid=1 and ready=0, data and last SHALL remain unchanged.
REQ-022 Once valid is asserted, it SHALL NOT drop until the word is accepted.
REQ-023 last SHALL equal 1 exactly when valid=1 and index=WORD_COUNT-1.
REQ-024 On a non-final transfer with GAP_CYCLES=0, the FSM SHALL stay in SEND with the next word presented on the following cycle (back-to-back, one word per cycle).
REQ-025 On a non-final transfer with GAP_CYCLES>0, the FSM SHALL go to GAP with valid=0 for exactly GAP_CYCLES cycles, then return to SEND with the next word.
REQ-026 The gap counter SHALL be independent of ready.
REQ-027 On the final transfer, the FSM SHALL go to FINISH with valid=0 and last=0, and no gap SHALL be applied.
REQ-028 In FINISH, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE unconditionally.
REQ-029 busy SHALL be 1 in SEND, GAP and FINISH, and 0 in IDLE.
REQ-030 start SHALL be ignored while busy=1, and requests SHALL NOT be queued.
REQ-031 A start in the same cycle as the return to IDLE (the cycle after done) SHALL be honoured.
REQ-032 The word index counter SHALL be 16 bits wide and SHALL never exceed WORD_COUNT-1.
REQ-033 WORD_COUNT=1 SHALL produce a single word with last=1 on its only beat.
REQ-034 All outputs SHALL be driven from registers, with no combinational path from ready or start to any output.

Reset
REQ-035 When rst=1 at a rising edge, the FSM SHALL enter IDLE with valid=0, last=0, busy=0, done=0, data=0, index=0 and gap counter=0.
REQ-036 Reset SHALL take priority over start and ready.
REQ-037 Reset mid-burst SHALL abandon the burst: valid SHALL drop on the next edge and done SHALL NOT pulse.
REQ-038 After reset deasserts, the module SHALL wait in IDLE for start.

Verification
REQ-039 The bench SHALL check defaults with ready held at 1 and a one-cycle start pulse: 16 beats 0..15 on consecutive cycles, last only on value 15, done one cycle after that beat, busy high for 17 cycles.
REQ-040 The bench SHALL check backpressure: ready toggling 1,0,0,1,... produces beats 0..15 in order, with no value repeated or skipped, and data/last stable during every ready=0 cycle with valid=1.
REQ-041 The bench SHALL check gap insertion with GAP_CYCLES=2 and ready=1: valid pattern 1,0,0,1,0,0,...,1 (final beat), total 46 cycles from first valid to done.
REQ-042 The bench SHALL check wrap-around with DATA_WIDTH=4, SEED=14, STRIDE=3, WORD_COUNT=4: data 14,1,4,7, with last on 7.
REQ-043 The bench SHALL check start while busy plus a reset mid-burst: a second start during beat 5 has no effect; rst at beat 8 gives valid=0 next cycle, no done pulse, and a new start gives data=SEED again.
REQ-044 The bench SHALL check WORD_COUNT=1 with ready=0 for 3 cycles and then 1: a single beat with last=1 held for 4 cycles, then done pulses once.
